// File: rtl/tt_um_jleugeri_ttt_host_driver_pkg.sv
// Shared encodings for the TTT host driver: core instructions, core stages and driver FSM states.
package tt_um_jleugeri_ttt_host_driver_pkg;

  typedef enum logic [3:0] {
    INSTR_BLOCK   = 4'b0000,
    INSTR_INPUT   = 4'b0001,
    INSTR_ADVANCE = 4'b0010
  } instr_e;

  // Only STAGE_INPUT matters to the driver; it is the stage in which the core takes inputs.
  typedef enum logic [1:0] {
    STAGE_INPUT    = 2'b00,
    STAGE_PROCESS  = 2'b01,
    STAGE_OUTPUT   = 2'b10,
    STAGE_RESERVED = 2'b11
  } stage_e;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_FEED,
    ST_ADVANCE,
    ST_WAIT_LEAVE,
    ST_WAIT_RETURN
  } state_e;

endpackage

// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// First-word-fall-through event FIFO with sticky overflow; push and pop may coincide even when full.
module tt_um_jleugeri_ttt_event_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_fast,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && not_empty;
  // When full, a same-cycle pop frees the slot the write pointer lands on.
  assign do_push   = push && (!full || do_pop);
  assign pop_data  = mem[rd_ptr];

  // NOTE: storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clock_fast) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_fast) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_host_driver.sv
// Host driver for the TTT core: feeds input events, advances timesteps when output space allows,
// and time-stamps core output events into a FIFO.
module tt_um_jleugeri_ttt_host_driver
  import tt_um_jleugeri_ttt_host_driver_pkg::*;
#(
  parameter  int NUM_PROCESSORS = 10,
  parameter  int NEW_TOKEN_BITS = 4,
  parameter  int TIMESTEP_BITS  = 16,
  parameter  int OUT_DEPTH      = 16,
  localparam int IN_ID_W        = $clog2(NUM_PROCESSORS + 1),
  localparam int OUT_ID_W       = $clog2(NUM_PROCESSORS)
) (
  input  logic                      clock_fast,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_ID_W-1:0]        in_processor_id,
  input  logic [NEW_TOKEN_BITS-1:0] in_good_tokens,
  input  logic [NEW_TOKEN_BITS-1:0] in_bad_tokens,
  input  logic                      in_last,
  input  logic                      run_enable,
  output logic [3:0]                instruction,
  output logic [IN_ID_W-1:0]        processor_id_in,
  output logic [NEW_TOKEN_BITS-1:0] good_tokens_in,
  output logic [NEW_TOKEN_BITS-1:0] bad_tokens_in,
  input  logic [1:0]                stage,
  input  logic [OUT_ID_W-1:0]       processor_id_out,
  input  logic [1:0]                token_startstop,
  input  logic                      output_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_ID_W-1:0]       out_processor_id,
  output logic [1:0]                out_startstop,
  output logic [TIMESTEP_BITS-1:0]  out_timestep,
  output logic [TIMESTEP_BITS-1:0]  timestep,
  output logic                      overflow,
  output logic                      busy
);

  localparam int CNT_W   = $clog2(OUT_DEPTH + 1);
  localparam int ENTRY_W = OUT_ID_W + 2 + TIMESTEP_BITS;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] NPROC_C = CNT_W'(NUM_PROCESSORS);

  if (OUT_DEPTH < NUM_PROCESSORS) begin : g_depth_check
    $error("OUT_DEPTH must be at least NUM_PROCESSORS");
  end

  state_e                    state, state_d;
  instr_e                    instr_q, instr_d;
  logic [IN_ID_W-1:0]        pid_d;
  logic [NEW_TOKEN_BITS-1:0] good_d, bad_d;
  logic                      handshake, is_null, advance_ok, ts_inc;
  logic [CNT_W-1:0]          fifo_count;
  logic [ENTRY_W-1:0]        fifo_head;

  assign in_ready    = (state == ST_FEED) && (stage == STAGE_INPUT);
  assign handshake   = in_valid && in_ready;
  assign is_null     = (in_processor_id == IN_ID_W'(NUM_PROCESSORS));
  // A timestep may emit one event per processor, so that much FIFO space must be free.
  assign advance_ok  = run_enable && ((DEPTH_C - fifo_count) >= NPROC_C);
  assign ts_inc      = (state == ST_WAIT_RETURN) && (stage == STAGE_INPUT);
  assign busy        = (state != ST_FEED);
  assign instruction = instr_q;

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      state           <= ST_WAIT_INIT;
      instr_q         <= INSTR_BLOCK;
      processor_id_in <= '0;
      good_tokens_in  <= '0;
      bad_tokens_in   <= '0;
      timestep        <= '0;
    end else begin
      state           <= state_d;
      instr_q         <= instr_d;
      processor_id_in <= pid_d;
      good_tokens_in  <= good_d;
      bad_tokens_in   <= bad_d;
      if (ts_inc) timestep <= timestep + TIMESTEP_BITS'(1);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_WAIT_INIT:   if (stage == STAGE_INPUT) state_d = ST_FEED;
      ST_FEED:        if (handshake && in_last) state_d = ST_ADVANCE;
      ST_ADVANCE:     if (advance_ok) state_d = ST_WAIT_LEAVE;
      ST_WAIT_LEAVE:  if (stage != STAGE_INPUT) state_d = ST_WAIT_RETURN;
      ST_WAIT_RETURN: if (stage == STAGE_INPUT) state_d = ST_FEED;
      default:        state_d = ST_WAIT_INIT;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    instr_d = INSTR_BLOCK;
    pid_d   = '0;
    good_d  = '0;
    bad_d   = '0;
    if (handshake && !is_null) begin
      instr_d = INSTR_INPUT;
      pid_d   = in_processor_id;
      good_d  = in_good_tokens;
      bad_d   = in_bad_tokens;
    end
    if ((state == ST_ADVANCE) && advance_ok) instr_d = INSTR_ADVANCE;
  end

  tt_um_jleugeri_ttt_event_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(OUT_DEPTH)
  ) u_event_fifo (
    .clock_fast(clock_fast),
    .reset     (reset),
    .push      (output_valid),
    .push_data ({processor_id_out, token_startstop, timestep}),
    .pop       (out_ready),
    .pop_data  (fifo_head),
    .not_empty (out_valid),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign {out_processor_id, out_startstop, out_timestep} = fifo_head;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_host_driver.sv
// Self-checking bench for the TTT host driver: table-driven input events plus FIFO scoreboard.
module tb_tt_um_jleugeri_ttt_host_driver;

  localparam int NP    = 10;
  localparam int TB    = 4;
  localparam int TSB   = 16;
  localparam int DEPTH = 16;
  localparam int IW    = $clog2(NP + 1);
  localparam int OW    = $clog2(NP);
  localparam int EW    = OW + 2 + TSB;

  logic           clock_fast = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, in_last, run_enable;
  logic [IW-1:0]  in_processor_id, processor_id_in;
  logic [TB-1:0]  in_good_tokens, in_bad_tokens, good_tokens_in, bad_tokens_in;
  logic [3:0]     instruction;
  logic [1:0]     stage, token_startstop, out_startstop;
  logic [OW-1:0]  processor_id_out, out_processor_id;
  logic           output_valid, out_valid, out_ready, overflow, busy;
  logic [TSB-1:0] out_timestep, timestep;

  tt_um_jleugeri_ttt_host_driver #(
    .NUM_PROCESSORS(NP), .NEW_TOKEN_BITS(TB), .TIMESTEP_BITS(TSB), .OUT_DEPTH(DEPTH)
  ) dut (
    .clock_fast(clock_fast), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_processor_id(in_processor_id),
    .in_good_tokens(in_good_tokens), .in_bad_tokens(in_bad_tokens), .in_last(in_last),
    .run_enable(run_enable), .instruction(instruction), .processor_id_in(processor_id_in),
    .good_tokens_in(good_tokens_in), .bad_tokens_in(bad_tokens_in), .stage(stage),
    .processor_id_out(processor_id_out), .token_startstop(token_startstop),
    .output_valid(output_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_processor_id(out_processor_id), .out_startstop(out_startstop),
    .out_timestep(out_timestep), .timestep(timestep), .overflow(overflow), .busy(busy)
  );

  always #5 clock_fast = ~clock_fast;

  typedef struct {
    logic [IW-1:0] id;
    logic [TB-1:0] good;
    logic [TB-1:0] bad;
    logic          last;
    logic [3:0]    exp_instr;
    logic [IW-1:0] exp_pid;
    logic [TB-1:0] exp_good;
    logic [TB-1:0] exp_bad;
  } ev_t;

  ev_t            vec[5];
  ev_t            instr_q[$];
  logic [EW-1:0]  fifo_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  logic           exp_ovf;
  logic [TSB-1:0] exp_ts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input int id, input int g, input int b, input int l,
                             input int ei, input int ep, input int eg, input int eb);
    ev_t e;
    e.id = IW'(id);  e.good = TB'(g);  e.bad = TB'(b);  e.last = (l != 0);
    e.exp_instr = 4'(ei);  e.exp_pid = IW'(ep);  e.exp_good = TB'(eg);  e.exp_bad = TB'(eb);
    return e;
  endfunction

  task automatic step();
    @(posedge clock_fast);
    #1;
  endtask

  // Called at posedge+1; returns at the negedge of the cycle after the handshake.
  task automatic apply(input ev_t e);
    ev_t x;
    in_valid = 1'b1;  in_processor_id = e.id;  in_good_tokens = e.good;
    in_bad_tokens = e.bad;  in_last = e.last;
    instr_q.push_back(e);
    @(negedge clock_fast);
    check("in_ready_feed", in_ready, 1);
    check("idle_instr", instruction, 4'b0000);
    step();
    in_valid = 1'b0;  in_last = 1'b0;
    @(negedge clock_fast);
    x = instr_q.pop_front();
    check("instr", instruction, x.exp_instr);
    check("pid_in", processor_id_in, x.exp_pid);
    check("good_in", good_tokens_in, x.exp_good);
    check("bad_in", bad_tokens_in, x.exp_bad);
  endtask

  // Called at posedge+1 of the cycle showing ADVANCE; returns at the negedge after FEED is re-entered.
  task automatic finish_advance();
    stage = 2'b01;
    @(negedge clock_fast);
    check("adv_instr", instruction, 4'b0010);
    check("adv_busy", busy, 1);
    step();
    stage = 2'b00;
    @(negedge clock_fast);
    check("leave_instr", instruction, 4'b0000);
    check("ts_hold", timestep, exp_ts);
    step();
    exp_ts++;
    @(negedge clock_fast);
    check("timestep", timestep, exp_ts);
    check("busy_feed", busy, 0);
  endtask

  // One cycle of core-event push and/or downstream pop; posedge+1 to posedge+1.
  task automatic fifo_cycle(input logic push, input logic [OW-1:0] pid, input logic [1:0] ss,
                            input logic pop);
    logic [EW-1:0] exp;
    output_valid = push;  processor_id_out = pid;  token_startstop = ss;  out_ready = pop;
    @(negedge clock_fast);
    check("out_valid", out_valid, fifo_q.size() != 0);
    check("overflow", overflow, exp_ovf);
    if (pop && fifo_q.size() != 0) begin
      exp = fifo_q.pop_front();
      check("out_entry", {out_processor_id, out_startstop, out_timestep}, exp);
    end
    if (push) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back({pid, ss, exp_ts});
      else exp_ovf = 1'b1;
    end
    step();
    output_valid = 1'b0;  out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;  stage = 2'b01;  in_valid = 1'b0;  in_processor_id = '0;
    in_good_tokens = '0;  in_bad_tokens = '0;  in_last = 1'b0;  run_enable = 1'b1;
    processor_id_out = '0;  token_startstop = '0;  output_valid = 1'b0;  out_ready = 1'b0;
    exp_ts = '0;  exp_ovf = 1'b0;

    vec[0] = mk(3,  2,  1, 0, 4'b0001, 3,  2,  1);
    vec[1] = mk(7, -1,  0, 1, 4'b0001, 7, -1,  0);
    vec[2] = mk(10, 1,  1, 1, 4'b0000, 0,  0,  0);
    vec[3] = mk(5, -8,  7, 0, 4'b0001, 5, -8,  7);
    vec[4] = mk(0,  0, -1, 1, 4'b0001, 0,  0, -1);

    // Reset state, then wait-for-init while the core is not in its input stage.
    repeat (2) step();
    @(negedge clock_fast);
    check("rst_instr", instruction, 4'b0000);
    check("rst_pid", processor_id_in, 0);
    check("rst_tokens", {good_tokens_in, bad_tokens_in}, 0);
    check("rst_timestep", timestep, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 1);
    step();
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock_fast);
      check("init_ready", in_ready, 0);
      step();
    end
    stage = 2'b00;
    @(negedge clock_fast);
    check("init_ready_last", in_ready, 0);
    step();
    @(negedge clock_fast);
    check("feed_ready", in_ready, 1);
    check("feed_busy", busy, 0);
    check("feed_instr", instruction, 4'b0000);
    step();

    // In FEED but core not in its input stage: nothing is accepted.
    stage = 2'b01;  in_valid = 1'b1;  in_processor_id = 4'd1;  in_last = 1'b1;
    @(negedge clock_fast);
    check("feed_stage_ready", in_ready, 0);
    step();
    in_valid = 1'b0;  in_last = 1'b0;  stage = 2'b00;
    @(negedge clock_fast);
    check("no_hs_instr", instruction, 4'b0000);
    check("no_hs_busy", busy, 0);
    step();

    for (int i = 0; i < 5; i++) begin
      apply(vec[i]);
      if (vec[i].last) begin
        step();
        finish_advance();
      end
      step();
    end

    // Seven queued events leave 9 free slots: ADVANCE must wait for one pop.
    for (int i = 0; i < 7; i++) fifo_cycle(1'b1, OW'(i), 2'(i), 1'b0);
    apply(mk(10, 0, 0, 1, 4'b0000, 0, 0, 0));
    repeat (3) begin
      step();
      @(negedge clock_fast);
      check("adv_hold_instr", instruction, 4'b0000);
      check("adv_hold_busy", busy, 1);
    end
    step();
    fifo_cycle(1'b0, '0, 2'b00, 1'b1);
    @(negedge clock_fast);
    check("adv_after_pop", instruction, 4'b0000);
    step();
    finish_advance();
    step();
    repeat (6) fifo_cycle(1'b0, '0, 2'b00, 1'b1);
    fifo_cycle(1'b0, '0, 2'b00, 1'b1);
    fifo_cycle(1'b1, OW'(9), 2'b11, 1'b0);
    fifo_cycle(1'b0, '0, 2'b00, 1'b1);

    // Fill past capacity, then push and pop together while full.
    for (int i = 0; i < 17; i++) fifo_cycle(1'b1, OW'(i % NP), 2'(i + 1), 1'b0);
    fifo_cycle(1'b1, OW'(5), 2'b10, 1'b1);
    repeat (16) fifo_cycle(1'b0, '0, 2'b00, 1'b1);
    fifo_cycle(1'b0, '0, 2'b00, 1'b0);

    // Reset while holding in ADVANCE with an input event in flight.
    run_enable = 1'b0;
    fifo_cycle(1'b1, OW'(4), 2'b01, 1'b0);
    apply(mk(2, 1, 1, 1, 4'b0001, 2, 1, 1));
    repeat (2) step();
    @(negedge clock_fast);
    check("hold_no_run", instruction, 4'b0000);
    step();
    reset = 1'b1;  in_valid = 1'b1;  in_processor_id = 4'd4;  in_good_tokens = 4'd3;
    step();
    fifo_q.delete();  exp_ovf = 1'b0;  exp_ts = '0;
    @(negedge clock_fast);
    check("rst2_instr", instruction, 4'b0000);
    check("rst2_timestep", timestep, 0);
    check("rst2_overflow", overflow, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_busy", busy, 1);
    check("rst2_ready", in_ready, 0);
    step();
    reset = 1'b0;  in_valid = 1'b0;
    step();
    @(negedge clock_fast);
    check("rst2_feed_busy", busy, 0);
    check("rst2_feed_instr", instruction, 4'b0000);
    check("rst2_feed_pid", processor_id_in, 0);
    step();
    fifo_cycle(1'b0, '0, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_jleugeri_ttt_host_driver.md
TT_UM_JLEUGERI_TTT_HOST_DRIVER -- requirements
Module: tt_um_jleugeri_ttt_host_driver

Interface
REQ-001 SHALL have parameter NUM_PROCESSORS, default 10, number of processors in the attached core.
REQ-002 SHALL have parameter NEW_TOKEN_BITS, default 4, signed token-delta width.
REQ-003 SHALL have parameter TIMESTEP_BITS, default 16, timestep counter width.
REQ-004 SHALL have parameter OUT_DEPTH, default 16, output event FIFO depth; elaboration error if OUT_DEPTH < NUM_PROCESSORS.
REQ-005 SHALL have ports, one per line:
- clock_fast  in  1  clock; all logic on its rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream input event valid
- in_ready  out  1  driver accepts the input event this cycle
- in_processor_id  in  clog2(NUM_PROCESSORS+1)  target processor; value NUM_PROCESSORS = null event
- in_good_tokens / in_bad_tokens  in  NEW_TOKEN_BITS  signed token deltas
- in_last  in  1  event closes the current timestep
- run_enable  in  1  permits a timestep to be advanced
- instruction  out  4  instruction to the core
- processor_id_in  out  clog2(NUM_PROCESSORS+1)  processor id to the core
- good_tokens_in / bad_tokens_in  out  NEW_TOKEN_BITS  tokens to the core
- stage  in  2  core stage
- processor_id_out  in  clog2(NUM_PROCESSORS)  core event source
- token_startstop  in  2  core event type {start,stop}
- output_valid  in  1  core event strobe
- out_valid  out  1  output FIFO not empty
- out_ready  in  1  downstream pops the head entry
- out_processor_id  out  clog2(NUM_PROCESSORS)  head entry: processor id
- out_startstop  out  2  head entry: event type
- out_timestep  out  TIMESTEP_BITS  head entry: timestep of the event
- timestep  out  TIMESTEP_BITS  completed-timestep count
- overflow  out  1  sticky; an event was dropped
- busy  out  1  state is not FEED

Function
REQ-006 SHALL drive instruction, processor_id_in, and token outputs from registers; bit 3 of instruction SHALL always be 0.
REQ-007 SHALL implement FSM states WAIT_INIT, FEED, ADVANCE, WAIT_LEAVE, WAIT_RETURN.
REQ-008 WAIT_INIT: instruction 0000; go to FEED on the first cycle stage==00.
REQ-009 FEED: in_ready = (state==FEED) && (stage==00), combinational; in all other cases in_ready=0.
REQ-010 On handshake with a non-null event: next cycle instruction=0001, processor_id_in/tokens = accepted values, held for exactly one cycle.
REQ-011 On handshake with a null event: instruction 0000; tokens not forwarded.
REQ-012 With no handshake in a cycle: instruction 0000 the next cycle.
REQ-013 A handshake with in_last=1 SHALL move the FSM to ADVANCE.
REQ-014 ADVANCE: when run_enable=1 and OUT_DEPTH-count >= NUM_PROCESSORS, drive instruction 0010 for one cycle and go to WAIT_LEAVE; otherwise hold ADVANCE with instruction 0000.
REQ-015 WAIT_LEAVE: instruction 0000; go to WAIT_RETURN on the first cycle stage!=00.
REQ-016 WAIT_RETURN: instruction 0000; when stage==00, increment timestep (mod 2^TIMESTEP_BITS wrap) and go to FEED.
REQ-017 Independent of FSM state, every cycle with output_valid=1 SHALL push {processor_id_out, token_startstop, timestep} into the output FIFO.
REQ-018 The FIFO SHALL be first-word-fall-through; a pop SHALL occur on out_valid && out_ready.
REQ-019 Simultaneous push and pop SHALL both take effect, including when the FIFO is full (count unchanged).
REQ-020 A push to a full FIFO without a pop SHALL drop the event and set overflow until reset.
REQ-021 Pop when empty SHALL be ignored.

Reset
REQ-022 Reset SHALL set the state to WAIT_INIT.
REQ-023 Reset SHALL set instruction=0000, processor_id_in=0, tokens=0, timestep=0, overflow=0, and empty the FIFO (out_valid=0).
REQ-024 Reset SHALL take effect from any state, including mid-ADVANCE or mid-FEED; an in-flight input event is discarded.

Structure
REQ-025 Instruction encodings (BLOCK=0000, INPUT=0001, ADVANCE=0010) and stage encodings SHALL live in the shared ttt package.
REQ-026 The output FIFO SHALL be the sub-module tt_um_jleugeri_ttt_event_fifo, parameterised by width and depth.

Verification
REQ-027 Reset, stage held 01 for 5 cycles then 00 -> in_ready=0 until stage=00, then FEED, instruction=0000.
REQ-028 Events (id 3,+2,+1), (id 7,-1,0,last) -> instruction 0001/3/+2/+1 then 0001/7/-1/0, then 0010 one cycle; stage 01..00 -> timestep=1.
REQ-029 Null event (id 10, last) -> no 0001 issued; single 0010 follows.
REQ-030 FIFO holds 7 entries (free 9 < 10), run_enable=1 -> ADVANCE holds with instruction 0000 until one pop, then 0010.
REQ-031 out_ready=0, 17 output_valid strobes after forcing the fill -> 16 entries, overflow=1; simultaneous push/pop at full -> count 16, overflow unchanged.
